// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: registered fetch with WAIT_STATES extra cycles and a stall request.
// Define INST_MEM_ERR_EN to flag misaligned or out-of-range fetches and return a NOP for them.
module inst_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           inst_o,
  output logic                  inst_valid,
  output logic                  stallreq_o,
  output logic                  err_o,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);
  localparam logic HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  addr_err;

  assign idx = addr_i[ADDR_WIDTH+1:2];

`ifdef INST_MEM_ERR_EN
  assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_WIDTH+2] != '0);
`else
  // Byte offset and upper bits are don't-care: the address wraps modulo depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[1:0], addr_i[31:ADDR_WIDTH+2]};
  assign addr_err = 1'b0;
`endif

  // Held low during reset so the controller never sees a stall before the first real fetch.
  assign stallreq_o = !rst && (((state == IDLE) && ce_i && HAS_WAIT) ||
                               ((state == WAIT) && (cnt != 4'd1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      inst_o     <= 32'h0;
      inst_valid <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (ce_i) begin
            if (!HAS_WAIT) begin
              inst_o     <= addr_err ? 32'h0 : mem[idx];
              inst_valid <= 1'b1;
              err_o      <= addr_err;
            end else begin
              addr_q <= idx;
              err_q  <= addr_err;
              cnt    <= WS4;
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // Final read uses addr_q at this edge, so load-port writes during the wait are seen.
          if (cnt == 4'd1) begin
            inst_o     <= err_q ? 32'h0 : mem[addr_q];
            inst_valid <= 1'b1;
            err_o      <= err_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-blocking write gives read-before-write against the fetch read above.
  always_ff @(posedge clk) begin
    if (!rst && ld_we_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Scoreboard bench: three responders (WAIT_STATES 0, 2, 3) sharing clock, reset and load port.
module tb_inst_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ce    [3];
  logic [31:0] addr  [3];
  logic [31:0] inst  [3];
  logic        valid [3];
  logic        stall [3];
  logic        err   [3];

  int tests = 0;
  int fails = 0;
  logic [32:0] sb [3][$];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      inst_mem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_STATES((gi == 0) ? 0 : gi + 1)
      ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce[gi]),
        .addr_i    (addr[gi]),
        .inst_o    (inst[gi]),
        .inst_valid(valid[gi]),
        .stallreq_o(stall[gi]),
        .err_o     (err[gi]),
        .ld_we_i   (ld_we),
        .ld_addr_i (ld_addr),
        .ld_data_i (ld_data)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then retire any responses against the scoreboard.
  task automatic tick();
    logic [32:0] e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (valid[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_valid%0d", i), {32'b0, valid[i]}, 33'd0);
        end else begin
          e = sb[i].pop_front();
          check($sformatf("resp%0d", i), {err[i], inst[i]}, e);
          $display("[TB] dut%0d resp inst=%h err=%b exp=%h", i, inst[i], err[i], e);
        end
      end
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
    $display("[TB] load mem[%0d]=%h", a, d);
  endtask

  task automatic fetch(input int i, input logic [31:0] a, input logic [32:0] exp, input int lat);
    int n;
    ce[i] = 1'b1; addr[i] = a;
    sb[i].push_back(exp);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) ce[i] = 1'b0;
    end while (sb[i].size() != 0 && n < 40);
    check($sformatf("latency%0d_%h", i, a), 33'(n), 33'(lat));
  endtask

  initial begin
    logic [32:0] e1000, e6;
    for (int i = 0; i < 3; i++) begin
      ce[i] = 1'b0; addr[i] = '0;
    end

    load(10'd0, 32'd11);
    load(10'd1, 32'd22);
    load(10'd2, 32'd33);

    // Reset with ce high.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) ce[i] = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_inst%0d", i), {1'b0, inst[i]}, 33'd0);
      check($sformatf("rst_valid%0d", i), {32'b0, valid[i]}, 33'd0);
      check($sformatf("rst_stall%0d", i), {32'b0, stall[i]}, 33'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) ce[i] = 1'b0;

    // Zero wait states, back-to-back.
    ce[0] = 1'b1; addr[0] = 32'd0; sb[0].push_back({1'b0, 32'd11});
    #1 check("b2b_stall_a", {32'b0, stall[0]}, 33'd0);
    tick();
    addr[0] = 32'd4; sb[0].push_back({1'b0, 32'd22});
    #1 check("b2b_stall_b", {32'b0, stall[0]}, 33'd0);
    tick();
    addr[0] = 32'd8; sb[0].push_back({1'b0, 32'd33});
    tick();
    ce[0] = 1'b0;
    tick();
    check("idle_valid0", {32'b0, valid[0]}, 33'd0);
    check("idle_hold0", {1'b0, inst[0]}, {1'b0, 32'd33});
    check("b2b_drained", 33'(sb[0].size()), 33'd0);

    // Two wait states.
    load(10'd1, 32'h3C01_0001);
    ce[1] = 1'b1; addr[1] = 32'd4; sb[1].push_back({1'b0, 32'h3C01_0001});
    #1 check("ws2_stall_c0", {32'b0, stall[1]}, 33'd1);
    tick();
    ce[1] = 1'b0;
    #1 check("ws2_stall_c1", {32'b0, stall[1]}, 33'd1);
    check("ws2_valid_c1", {32'b0, valid[1]}, 33'd0);
    tick();
    check("ws2_stall_c2", {32'b0, stall[1]}, 33'd0);
    check("ws2_valid_c2", {32'b0, valid[1]}, 33'd0);
    tick();
    check("ws2_drained", 33'(sb[1].size()), 33'd0);

    // Same-edge write returns the old word, refetch the new one.
    ce[0] = 1'b1; addr[0] = 32'd4;
    ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEAD_BEEF;
    sb[0].push_back({1'b0, 32'h3C01_0001});
    tick();
    ld_we = 1'b0;
    sb[0].push_back({1'b0, 32'hDEAD_BEEF});
    tick();
    ce[0] = 1'b0;
    tick();
    check("rbw_drained", 33'(sb[0].size()), 33'd0);

`ifdef INST_MEM_ERR_EN
    e1000 = {1'b1, 32'h0};
    e6    = {1'b1, 32'h0};
`else
    e1000 = {1'b0, 32'd11};
    e6    = {1'b0, 32'hDEAD_BEEF};
`endif
    fetch(0, 32'h0000_1000, e1000, 1);
    fetch(0, 32'h0000_0006, e6, 1);
    fetch(1, 32'h0000_1000, e1000, 3);
    fetch(1, 32'h0000_0008, {1'b0, 32'd33}, 3);

    // Write into the latched word while the fetch waits.
    ce[2] = 1'b1; addr[2] = 32'd8; sb[2].push_back({1'b0, 32'h77});
    tick();
    ce[2] = 1'b0;
    load(10'd2, 32'h77);
    tick();
    tick();
    check("wait_write_drained", 33'(sb[2].size()), 33'd0);

    // Reset aborts a fetch after one wait cycle.
    ce[2] = 1'b1; addr[2] = 32'd0;
    tick();
    ce[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("abort_valid", {32'b0, valid[2]}, 33'd0);
    check("abort_stall", {32'b0, stall[2]}, 33'd0);
    for (int k = 0; k < 4; k++) tick();
    fetch(2, 32'd0, {1'b0, 32'd11}, 4);

    for (int i = 0; i < 3; i++)
      check($sformatf("final_empty%0d", i), 33'(sb[i].size()), 33'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
